// File: rtl/adc_serial_emulator.sv
// Serial ADC responder: answers a chip_select/ADC_clk reader with 4 zeros + 12 data bits
// per channel. Define ADC_EMU_RAMP_EN to replace the sample inputs with an internal ramp.
`timescale 1ns/1ps

module adc_serial_emulator (
   input  logic        fpga_clk,
   input  logic        reset,
   input  logic        ADC_clk,
   input  logic        chip_select,
   output logic        serial_data1,
   output logic        serial_data2,
   input  logic [11:0] sample1,
   input  logic [11:0] sample2,
   input  logic        sample_valid,
   output logic        frame_done,
   output logic [15:0] frame_count,
   output logic [1:0]  fsm_state
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LEAD = 2'd1,
      DATA = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t      state;
   logic        adc_meta, adc_sync, adc_prev;
   logic        cs_meta, cs_sync, cs_prev;
   logic        adc_fall, cs_fall, cs_rise;
   logic [11:0] hold1, hold2;
   logic [11:0] load1, load2;
   logic [11:0] shift1, shift2;
   logic [3:0]  bit_cnt;

   // Two-flop synchronizers plus one history flop for edge detection; chip_select idles high.
   always_ff @(posedge fpga_clk or negedge reset) begin
      if (!reset) begin
         adc_meta <= 1'b0;
         adc_sync <= 1'b0;
         adc_prev <= 1'b0;
         cs_meta  <= 1'b1;
         cs_sync  <= 1'b1;
         cs_prev  <= 1'b1;
      end else begin
         adc_meta <= ADC_clk;
         adc_sync <= adc_meta;
         adc_prev <= adc_sync;
         cs_meta  <= chip_select;
         cs_sync  <= cs_meta;
         cs_prev  <= cs_sync;
      end
   end

   assign adc_fall = adc_prev & ~adc_sync;
   assign cs_fall  = cs_prev & ~cs_sync;
   assign cs_rise  = ~cs_prev & cs_sync;

`ifdef ADC_EMU_RAMP_EN
   logic [11:0] ramp;
   logic        unused_inputs;

   assign unused_inputs = ^{sample1, sample2, sample_valid};

   always_ff @(posedge fpga_clk or negedge reset) begin
      if (!reset) begin
         ramp <= 12'd0;
      end else if (frame_done) begin
         ramp <= ramp + 12'd1;
      end
   end

   assign hold1 = ramp;
   assign hold2 = 12'hFFF - ramp;
   assign load1 = hold1;
   assign load2 = hold2;
`else
   always_ff @(posedge fpga_clk or negedge reset) begin
      if (!reset) begin
         hold1 <= 12'd0;
         hold2 <= 12'd0;
      end else if (sample_valid) begin
         hold1 <= sample1;
         hold2 <= sample2;
      end
   end

   // A sample arriving with the frame start goes straight into the shifters.
   assign load1 = sample_valid ? sample1 : hold1;
   assign load2 = sample_valid ? sample2 : hold2;
`endif

   always_ff @(posedge fpga_clk or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         shift1       <= 12'd0;
         shift2       <= 12'd0;
         bit_cnt      <= 4'd0;
         serial_data1 <= 1'b0;
         serial_data2 <= 1'b0;
         frame_done   <= 1'b0;
         frame_count  <= 16'd0;
      end else begin
         frame_done <= 1'b0;
         case (state)
            IDLE: begin
               serial_data1 <= 1'b0;
               serial_data2 <= 1'b0;
               if (cs_fall) begin
                  shift1  <= load1;
                  shift2  <= load2;
                  bit_cnt <= 4'd0;
                  state   <= LEAD;
               end
            end
            LEAD: begin
               if (cs_rise) begin
                  state        <= IDLE;
                  serial_data1 <= 1'b0;
                  serial_data2 <= 1'b0;
               end else if (adc_fall) begin
                  bit_cnt <= bit_cnt + 4'd1;
                  if (bit_cnt == 4'd3) begin
                     state        <= DATA;
                     serial_data1 <= shift1[11];
                     serial_data2 <= shift2[11];
                     shift1       <= {shift1[10:0], 1'b0};
                     shift2       <= {shift2[10:0], 1'b0};
                  end else begin
                     serial_data1 <= 1'b0;
                     serial_data2 <= 1'b0;
                  end
               end
            end
            DATA: begin
               if (cs_rise) begin
                  state        <= IDLE;
                  serial_data1 <= 1'b0;
                  serial_data2 <= 1'b0;
               end else if (adc_fall) begin
                  bit_cnt <= bit_cnt + 4'd1;
                  // The 16th fall closes the frame; bits 1..15 were driven by falls 1..15.
                  if (bit_cnt == 4'd15) begin
                     state        <= DONE;
                     serial_data1 <= 1'b0;
                     serial_data2 <= 1'b0;
                     frame_done   <= 1'b1;
                     frame_count  <= frame_count + 16'd1;
                  end else begin
                     serial_data1 <= shift1[11];
                     serial_data2 <= shift2[11];
                     shift1       <= {shift1[10:0], 1'b0};
                     shift2       <= {shift2[10:0], 1'b0};
                  end
               end
            end
            DONE: begin
               serial_data1 <= 1'b0;
               serial_data2 <= 1'b0;
               if (cs_rise) begin
                  state <= IDLE;
               end
            end
            default: begin
               state        <= IDLE;
               serial_data1 <= 1'b0;
               serial_data2 <= 1'b0;
            end
         endcase
      end
   end

   assign fsm_state = state;

endmodule
